fft_stage_ctrl: RTL and testbench

Frame-level sequencer for the FFT pipeline. It accepts one input frame per start request and loads it into SRAM through a valid/ready handshake. It then drives the bit-reversal address generator, steps the butterfly engine through its passes, waits out the pipeline drain, and holds a done level until the consumer acknowledges. It sits above the address generators and the butterfly datapath, and owns the ping-pong bank select.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_stage_ctrl.sv | 158 +++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT pipeline control blocks.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        REORDER = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } fft_ctrl_state_e;

    localparam int unsigned DefaultAddrWidth = 7;
    localparam int unsigned N = 1 << DefaultAddrWidth;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_stage_ctrl.sv
// Frame-level sequencer: load, bit-reversal reorder, butterfly passes, drain, done handshake.
// Owns the ping-pong bank select and the completed-frame counter.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned AddrWidth   = DefaultAddrWidth,
    parameter int unsigned NumPasses   = 7,
    parameter int unsigned DrainCycles = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    output logic [AddrWidth-1:0]                load_addr_o,
    output logic                                stage1_o,
    output logic                                reorder_start_o,
    input  logic                                fft_start_i,
    output logic                                pass_start_o,
    output logic [idx_width(NumPasses)-1:0]     pass_idx_o,
    input  logic                                pass_done_i,
    output logic                                done_o,
    input  logic                                out_ack_i,
    output logic                                busy_o,
    output logic                                bank_sel_o,
    output logic [7:0]                          frame_cnt_o,
    output logic                                err_o
);

    localparam int unsigned PassW  = idx_width(NumPasses);
    localparam int unsigned DrainW = idx_width(DrainCycles);
    localparam logic [PassW-1:0]  LastPass  = PassW'(NumPasses - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(DrainCycles - 1);

    fft_ctrl_state_e      state_q, state_d;
    logic [AddrWidth-1:0] load_addr_q, load_addr_d;
    logic [PassW-1:0]     pass_idx_q, pass_idx_d;
    logic [DrainW-1:0]    drain_cnt_q, drain_cnt_d;
    logic                 reorder_start_q, reorder_start_d;
    logic                 pass_start_q, pass_start_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 bank_sel_q, bank_sel_d;
    logic                 err_q, err_d;
    logic                 proto_err;

    assign proto_err = (start_i && state_q != IDLE)
                     || (fft_start_i && state_q != REORDER)
                     || (pass_done_i && state_q != COMPUTE)
                     || (out_ack_i && state_q != DONE);

    always_comb begin
        state_d         = state_q;
        load_addr_d     = load_addr_q;
        pass_idx_d      = pass_idx_q;
        drain_cnt_d     = drain_cnt_q;
        reorder_start_d = 1'b0;
        pass_start_d    = 1'b0;
        frame_cnt_d     = frame_cnt_q;
        bank_sel_d      = bank_sel_q;
        err_d           = err_q;

        if (abort_i) begin
            // Abort overrides every other input, including error capture.
            state_d     = IDLE;
            load_addr_d = '0;
            pass_idx_d  = '0;
            drain_cnt_d = '0;
        end else begin
            if (proto_err) err_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d     = LOAD;
                        load_addr_d = '0;
                        err_d       = 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        load_addr_d = load_addr_q + AddrWidth'(1);
                        if (load_addr_q == '1) begin
                            state_d         = REORDER;
                            reorder_start_d = 1'b1;
                        end
                    end
                end
                REORDER: begin
                    if (fft_start_i) begin
                        state_d      = COMPUTE;
                        pass_idx_d   = '0;
                        pass_start_d = 1'b1;
                    end
                end
                COMPUTE: begin
                    if (pass_done_i) begin
                        if (pass_idx_q == LastPass) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end else begin
                            pass_idx_d   = pass_idx_q + PassW'(1);
                            pass_start_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == LastDrain) state_d = DONE;
                    else drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
                DONE: begin
                    if (out_ack_i) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        bank_sel_d  = ~bank_sel_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            load_addr_q     <= '0;
            pass_idx_q      <= '0;
            drain_cnt_q     <= '0;
            reorder_start_q <= 1'b0;
            pass_start_q    <= 1'b0;
            frame_cnt_q     <= 8'd0;
            bank_sel_q      <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            load_addr_q     <= load_addr_d;
            pass_idx_q      <= pass_idx_d;
            drain_cnt_q     <= drain_cnt_d;
            reorder_start_q <= reorder_start_d;
            pass_start_q    <= pass_start_d;
            frame_cnt_q     <= frame_cnt_d;
            bank_sel_q      <= bank_sel_d;
            err_q           <= err_d;
        end
    end

    assign in_ready_o      = (state_q == LOAD);
    assign load_addr_o     = load_addr_q;
    assign stage1_o        = (state_q == REORDER);
    assign reorder_start_o = reorder_start_q;
    assign pass_start_o    = pass_start_q;
    assign pass_idx_o      = pass_idx_q;
    assign done_o          = (state_q == DONE);
    assign busy_o          = (state_q != IDLE);
    assign bank_sel_o      = bank_sel_q;
    assign frame_cnt_o     = frame_cnt_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed self-checking bench for fft_stage_ctrl with default parameters (N=128, 7 passes, drain 4).
module tb_fft_stage_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i, abort_i, in_valid_i, fft_start_i, pass_done_i, out_ack_i;
    logic       in_ready_o, stage1_o, reorder_start_o, pass_start_o, done_o;
    logic       busy_o, bank_sel_o, err_o;
    logic [6:0] load_addr_o;
    logic [2:0] pass_idx_o;
    logic [7:0] frame_cnt_o;

    int checks   = 0;
    int failures = 0;
    int n;
    int pulses;
    int i;
    bit flag;
    bit ok;
    bit bank_ok;
    logic [7:0] cnt_at_255;

    fft_stage_ctrl #(
        .AddrWidth  (7),
        .NumPasses  (7),
        .DrainCycles(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .load_addr_o    (load_addr_o),
        .stage1_o       (stage1_o),
        .reorder_start_o(reorder_start_o),
        .fft_start_i    (fft_start_i),
        .pass_start_o   (pass_start_o),
        .pass_idx_o     (pass_idx_o),
        .pass_done_i    (pass_done_i),
        .done_o         (done_o),
        .out_ack_i      (out_ack_i),
        .busy_o         (busy_o),
        .bank_sel_o     (bank_sel_o),
        .frame_cnt_o    (frame_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full frame: in_valid held high, zero-length passes, ack on the first done cycle.
    task automatic run_frame(output bit ok_o);
        int m;
        ok_o = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        m = 0;
        while (in_ready_o && m < 300) begin
            tick();
            m++;
        end
        in_valid_i = 1'b0;
        if (m != 128 || !reorder_start_o) ok_o = 1'b0;
        fft_start_i = 1'b1;
        tick();
        fft_start_i = 1'b0;
        pass_done_i = 1'b1;
        for (int p = 0; p < 7; p++) begin
            if (!pass_start_o || pass_idx_o != 3'(p)) ok_o = 1'b0;
            tick();
        end
        pass_done_i = 1'b0;
        m = 0;
        while (!done_o && m < 50) begin
            tick();
            m++;
        end
        if (m != 4) ok_o = 1'b0;
        out_ack_i = 1'b1;
        tick();
        out_ack_i = 1'b0;
        if (done_o || busy_o || err_o) ok_o = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        in_valid_i = 1'b0;
        fft_start_i = 1'b0;
        pass_done_i = 1'b0;
        out_ack_i = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready_o, 0);
        check("rst_load_addr", load_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        check("rst_misc", {stage1_o, reorder_start_o, pass_start_o, pass_idx_o, bank_sel_o, err_o},
              0);
        #2 rst_i = 1'b0;
        tick();

        // Nominal frame
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_in_ready", in_ready_o, 1);
        check("start_busy", busy_o, 1);
        in_valid_i = 1'b1;
        n = 0;
        flag = 1'b1;
        while (in_ready_o && n < 1000) begin
            if (load_addr_o != 7'(n)) flag = 1'b0;
            tick();
            n++;
        end
        in_valid_i = 1'b0;
        check("load_cycles", n, 128);
        check("load_addr_seq", flag, 1);
        check("load_addr_wrap", load_addr_o, 0);
        check("reorder_entry", {stage1_o, reorder_start_o}, 2'b11);
        tick();
        check("reorder_pulse_end", {stage1_o, reorder_start_o}, 2'b10);
        fft_start_i = 1'b1;
        tick();
        fft_start_i = 1'b0;
        check("first_pass", {pass_start_o, pass_idx_o}, 4'b1000);
        pulses = 1;
        flag = 1'b1;
        for (int p = 0; p < 7; p++) begin
            tick();
            if (pass_start_o || pass_idx_o != 3'(p)) flag = 1'b0;
            pass_done_i = 1'b1;
            tick();
            pass_done_i = 1'b0;
            if (pass_start_o && pass_idx_o == 3'(p + 1)) pulses++;
        end
        check("pass_pulses", pulses, 7);
        check("pass_gaps", flag, 1);
        n = 1;
        while (!done_o && n < 50) begin
            tick();
            n++;
        end
        check("drain_latency", n, 5);
        out_ack_i = 1'b1;
        tick();
        out_ack_i = 1'b0;
        check("ack_done_busy", {done_o, busy_o}, 0);
        check("ack_frame_cnt", frame_cnt_o, 1);
        check("ack_bank", bank_sel_o, 1);
        check("nominal_err", err_o, 0);

        // Gapped input
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        flag = 1'b1;
        while (in_ready_o && n < 1000) begin
            if (load_addr_o != 7'(n / 2)) flag = 1'b0;
            in_valid_i = n[0];
            tick();
            n++;
        end
        in_valid_i = 1'b0;
        check("gapped_cycles", n, 256);
        check("gapped_addr", flag, 1);
        check("gapped_reorder", stage1_o, 1);
        fft_start_i = 1'b1;
        tick();
        fft_start_i = 1'b0;
        pass_done_i = 1'b1;
        repeat (7) tick();
        pass_done_i = 1'b0;
        n = 0;
        while (!done_o && n < 50) begin
            tick();
            n++;
        end
        out_ack_i = 1'b1;
        tick();
        out_ack_i = 1'b0;
        check("gapped_frame_cnt", frame_cnt_o, 2);
        check("gapped_bank", bank_sel_o, 0);

        // Protocol errors
        start_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        check("err_start_in_load", err_o, 1);
        check("err_no_state_change", {in_ready_o, load_addr_o}, 8'h80);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_keeps_err", {busy_o, err_o}, 2'b01);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_clears_err", {busy_o, err_o}, 2'b10);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        pass_done_i = 1'b1;
        tick();
        pass_done_i = 1'b0;
        check("err_pass_done_idle", {busy_o, err_o}, 2'b01);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_clears_err2", {busy_o, err_o}, 2'b10);
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_start_idle", busy_o, 0);

        // Abort during COMPUTE at pass 3
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        n = 0;
        while (in_ready_o && n < 300) begin
            tick();
            n++;
        end
        in_valid_i = 1'b0;
        fft_start_i = 1'b1;
        tick();
        fft_start_i = 1'b0;
        repeat (3) begin
            pass_done_i = 1'b1;
            tick();
            pass_done_i = 1'b0;
            tick();
        end
        check("pre_abort_pass", pass_idx_o, 3);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_idle", {busy_o, pass_start_o, pass_idx_o, done_o}, 0);
        check("abort_frame_cnt", frame_cnt_o, 2);
        check("abort_bank", bank_sel_o, 0);
        run_frame(ok);
        check("post_abort_frame", ok, 1);
        check("post_abort_cnt", {frame_cnt_o, bank_sel_o}, {8'd3, 1'b1});

        // Asynchronous reset mid-LOAD
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        repeat (10) tick();
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_outputs", {in_ready_o, load_addr_o, busy_o, bank_sel_o, err_o}, 0);
        check("async_rst_cnt", frame_cnt_o, 0);
        in_valid_i = 1'b0;
        #3 rst_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_after_rst", {in_ready_o, busy_o}, 2'b11);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;

        // 256 back-to-back frames with zero-length passes
        flag = 1'b1;
        bank_ok = 1'b1;
        cnt_at_255 = 8'd0;
        for (i = 0; i < 256; i++) begin
            run_frame(ok);
            if (!ok) flag = 1'b0;
            if (bank_sel_o != 1'((i + 1) % 2)) bank_ok = 1'b0;
            if (i == 254) cnt_at_255 = frame_cnt_o;
        end
        check("b2b_frames_ok", flag, 1);
        check("b2b_bank_alt", bank_ok, 1);
        check("b2b_cnt_255", cnt_at_255, 255);
        check("b2b_cnt_wrap", frame_cnt_o, 0);
        check("b2b_err", err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
